// File: rtl/nvdla_package.sv
// Shared types for the NVDLA CSB master engine: control/flag bundles,
// the CSB state encoding and the default access timeout.
package nvdla_package;

    // Default number of cycles an access may stay outstanding before aborting
    localparam int unsigned NVDLA_CSB_TIMEOUT = 4096;

    // Per-access control from the engine control FSM
    typedef struct packed {
        logic        clear;
        logic        enable;
        logic        start;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        wait_intr;
    } ctrl_engine_t;

    // Status back to the control FSM; all but csb_ready are one-cycle pulses
    typedef struct packed {
        logic csb_ready;
        logic csb_valid;
        logic csb_wr_complete;
        logic intr;
        logic err;
    } flags_engine_t;

    typedef enum logic [2:0] {
        CSB_IDLE      = 3'd0,
        CSB_REQ       = 3'd1,
        CSB_WAIT_RD   = 3'd2,
        CSB_WAIT_WR   = 3'd3,
        CSB_PUSH      = 3'd4,
        CSB_WAIT_INTR = 3'd5
    } csb_state_t;

    // States in which the access timeout counter is live
    function automatic logic csb_is_timed(input csb_state_t s);
        return (s == CSB_REQ) || (s == CSB_WAIT_RD) || (s == CSB_WAIT_WR);
    endfunction

endpackage

// File: rtl/nvdla_intr_sync.sv
// Brings the asynchronous NVDLA interrupt level into clk_i, detects its
// rising edge and holds a sticky pending bit until cleared or consumed.
module nvdla_intr_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic intr_i,
    input  logic clear_i,
    input  logic consume_i,
    output logic pending_o
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise    = r_sync2 & ~r_prev;
    assign pending_o = r_pending;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= intr_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Sticky pending: clear wins; a fresh edge beats consumption so it is never lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= 1'b0;
        end else if (clear_i) begin
            r_pending <= 1'b0;
        end else if (w_rise) begin
            r_pending <= 1'b1;
        end else if (consume_i) begin
            r_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/nvdla_csb_master.sv
// CSB master engine: issues one CSB read or write per start, returns read
// data on a valid/ready stream, optionally waits for the NVDLA interrupt,
// and aborts accesses that stay outstanding for TIMEOUT_CYCLES cycles.
module nvdla_csb_master
    import nvdla_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = NVDLA_CSB_TIMEOUT,
    parameter int unsigned ADDR_W         = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  ctrl_engine_t         ctrl_i,
    output flags_engine_t        flags_o,
    output logic                 csb2nvdla_valid,
    input  logic                 csb2nvdla_ready,
    output logic [ADDR_W-1:0]    csb2nvdla_addr,
    output logic [31:0]          csb2nvdla_wdat,
    output logic                 csb2nvdla_write,
    output logic                 csb2nvdla_nposted,
    input  logic                 nvdla2csb_valid,
    input  logic [31:0]          nvdla2csb_data,
    input  logic                 nvdla2csb_wr_complete,
    input  logic                 dla_intr_i,
    output logic                 rdata_o_valid,
    input  logic                 rdata_o_ready,
    output logic [31:0]          rdata_o_data
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    csb_state_t         r_state;
    csb_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdat;
    logic               r_write;
    logic [31:0]        r_rdata;

    logic               w_clear;
    logic               w_timeout;
    logic               w_pending;
    logic               w_consume;
    logic               w_latch;
    logic               w_capture;
    logic               w_req_valid;
    logic               w_push_valid;
    flags_engine_t      w_flags;
    logic               w_unused_addr;

    // Only the word-address slice of the byte address reaches the bus
    assign w_unused_addr = ^ctrl_i.addr;

    assign w_clear   = clear_i | ctrl_i.clear;
    assign w_timeout = csb_is_timed(r_state) && (r_cnt == CNT_LAST);

    nvdla_intr_sync u_intr_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .intr_i    (dla_intr_i),
        .clear_i   (w_clear),
        .consume_i (w_consume),
        .pending_o (w_pending)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= CSB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshakes and flag pulses; a handshake or response in the
    // last timeout cycle still completes normally
    always_comb begin
        w_state_next      = r_state;
        w_flags           = '0;
        w_flags.csb_ready = (r_state == CSB_IDLE);
        w_req_valid       = 1'b0;
        w_push_valid      = 1'b0;
        w_latch           = 1'b0;
        w_capture         = 1'b0;
        w_consume         = 1'b0;
        if (w_clear) begin
            w_state_next = CSB_IDLE;
        end else begin
            case (r_state)
                CSB_IDLE: begin
                    if (ctrl_i.start && ctrl_i.enable) begin
                        w_latch      = 1'b1;
                        w_state_next = ctrl_i.wait_intr ? CSB_WAIT_INTR : CSB_REQ;
                    end
                end
                CSB_REQ: begin
                    w_req_valid = 1'b1;
                    if (csb2nvdla_ready) begin
                        w_state_next = r_write ? CSB_WAIT_WR : CSB_WAIT_RD;
                    end else if (w_timeout) begin
                        w_flags.err  = 1'b1;
                        w_state_next = CSB_IDLE;
                    end
                end
                CSB_WAIT_RD: begin
                    if (nvdla2csb_valid) begin
                        w_capture    = 1'b1;
                        w_state_next = CSB_PUSH;
                    end else if (w_timeout) begin
                        w_flags.err  = 1'b1;
                        w_state_next = CSB_IDLE;
                    end
                end
                CSB_WAIT_WR: begin
                    if (nvdla2csb_wr_complete) begin
                        w_flags.csb_wr_complete = 1'b1;
                        w_state_next            = CSB_IDLE;
                    end else if (w_timeout) begin
                        w_flags.err  = 1'b1;
                        w_state_next = CSB_IDLE;
                    end
                end
                CSB_PUSH: begin
                    w_push_valid = 1'b1;
                    if (rdata_o_ready) begin
                        w_flags.csb_valid = 1'b1;
                        w_state_next      = CSB_IDLE;
                    end
                end
                CSB_WAIT_INTR: begin
                    if (w_pending) begin
                        w_flags.intr = 1'b1;
                        w_consume    = 1'b1;
                        w_state_next = CSB_IDLE;
                    end
                end
                default: begin
                    w_state_next = CSB_IDLE;
                end
            endcase
        end
    end

    // Timeout counter: restarts on every state change, saturates at the last value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || !csb_is_timed(r_state)) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Request payload latched on start, read data captured on response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_wdat  <= '0;
            r_write <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_latch) begin
                r_addr  <= ctrl_i.addr[ADDR_W+1:2];
                r_wdat  <= ctrl_i.wdat;
                r_write <= ctrl_i.write;
            end
            if (w_capture) begin
                r_rdata <= nvdla2csb_data;
            end
        end
    end

    assign flags_o           = w_flags;
    assign csb2nvdla_valid   = w_req_valid;
    assign csb2nvdla_addr    = r_addr;
    assign csb2nvdla_wdat    = r_wdat;
    assign csb2nvdla_write   = r_write;
    assign csb2nvdla_nposted = 1'b1;
    assign rdata_o_valid     = w_push_valid;
    assign rdata_o_data      = r_rdata;

endmodule

// File: tb/tb_nvdla_csb_master.sv
// Directed bench for nvdla_csb_master with a per-cycle reference model.
module tb_nvdla_csb_master;
    import nvdla_package::*;

    localparam int TMO = 16;
    localparam int AW  = 16;
    localparam int P_IDLE = 0, P_REQ = 1, P_RD = 2, P_WR = 3, P_PUSH = 4, P_WINT = 5;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          clear_i = 1'b0;
    ctrl_engine_t  ctrl;
    flags_engine_t flags;
    logic          req_valid, req_ready, req_write, req_nposted;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdat;
    logic          rsp_valid, rsp_wrc, dla_intr;
    logic [31:0]   rsp_data;
    logic          rd_valid, rd_ready;
    logic [31:0]   rd_data;

    nvdla_csb_master #(.TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .ctrl_i(ctrl), .flags_o(flags),
        .csb2nvdla_valid(req_valid), .csb2nvdla_ready(req_ready), .csb2nvdla_addr(req_addr),
        .csb2nvdla_wdat(req_wdat), .csb2nvdla_write(req_write), .csb2nvdla_nposted(req_nposted),
        .nvdla2csb_valid(rsp_valid), .nvdla2csb_data(rsp_data), .nvdla2csb_wr_complete(rsp_wrc),
        .dla_intr_i(dla_intr), .rdata_o_valid(rd_valid), .rdata_o_ready(rd_ready), .rdata_o_data(rd_data)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: what a transaction must look like from the rules alone
    int          m_ph, m_wait, nph;
    logic [31:0] m_addr, m_wdat, m_data;
    logic        m_write, m_pend;
    logic [2:0]  m_smp;          // last three sampled interrupt levels, [0] newest
    logic        clr, tmo, rise;
    logic        e_ready, e_req, e_rd, e_cv, e_wrc, e_intr, e_err;

    // Event log taken from the DUT, used by the directed literal checks
    int          n_cv = 0, n_wrc = 0, n_intr = 0, n_err = 0, n_stall_req = 0, n_stall_push = 0;
    int          cv_cyc = -1, intr_cyc = -1, err_cyc = -1;
    logic [31:0] hs_addr, hs_wdat, last_rdata;
    logic        hs_write, hs_nposted;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            m_ph = P_IDLE; m_wait = 0; m_addr = 0; m_wdat = 0; m_data = 0;
            m_write = 0; m_pend = 0; m_smp = 3'b000;
            chk("rst_csb_ready", flags.csb_ready, 1'b1);
            chk("rst_pulses", {flags.csb_valid, flags.csb_wr_complete, flags.intr, flags.err}, 4'b0);
            chk("rst_req_valid", req_valid, 1'b0);
            chk("rst_rd_valid", rd_valid, 1'b0);
        end else begin
            clr    = clear_i | ctrl.clear;
            tmo    = (m_ph == P_REQ || m_ph == P_RD || m_ph == P_WR) && (m_wait == TMO - 1);
            e_ready = (m_ph == P_IDLE);
            e_req  = (m_ph == P_REQ) && !clr;
            e_rd   = (m_ph == P_PUSH) && !clr;
            e_cv   = e_rd && rd_ready;
            e_wrc  = (m_ph == P_WR) && !clr && rsp_wrc;
            e_intr = (m_ph == P_WINT) && !clr && m_pend;
            e_err  = !clr && tmo && ((m_ph == P_REQ && !req_ready) ||
                                     (m_ph == P_RD && !rsp_valid) ||
                                     (m_ph == P_WR && !rsp_wrc));
            chk("csb_ready", flags.csb_ready, e_ready);
            chk("csb_valid", flags.csb_valid, e_cv);
            chk("csb_wr_complete", flags.csb_wr_complete, e_wrc);
            chk("intr", flags.intr, e_intr);
            chk("err", flags.err, e_err);
            chk("req_valid", req_valid, e_req);
            chk("rd_valid", rd_valid, e_rd);
            if (e_req) begin
                chk("req_addr", req_addr, m_addr[AW+1:2]);
                chk("req_wdat", req_wdat, m_wdat);
                chk("req_write", req_write, m_write);
                chk("req_nposted", req_nposted, 1'b1);
            end
            if (e_rd) chk("rd_data", rd_data, m_data);

            // log actual DUT events
            if (flags.csb_valid) begin n_cv++; cv_cyc = cyc; last_rdata = rd_data; end
            if (flags.csb_wr_complete) n_wrc++;
            if (flags.intr) begin n_intr++; intr_cyc = cyc; end
            if (flags.err) begin n_err++; err_cyc = cyc; end
            if (req_valid && !req_ready) n_stall_req++;
            if (rd_valid && !rd_ready) n_stall_push++;
            if (req_valid && req_ready) begin
                hs_addr = 32'(req_addr); hs_wdat = req_wdat; hs_write = req_write; hs_nposted = req_nposted;
            end

            // advance model to the next cycle
            nph = m_ph;
            if (clr) nph = P_IDLE;
            else if (e_err) nph = P_IDLE;
            else begin
                case (m_ph)
                    P_IDLE: if (ctrl.start && ctrl.enable) begin
                        nph = ctrl.wait_intr ? P_WINT : P_REQ;
                        m_addr = ctrl.addr; m_wdat = ctrl.wdat; m_write = ctrl.write;
                    end
                    P_REQ:  if (req_ready) nph = m_write ? P_WR : P_RD;
                    P_RD:   if (rsp_valid) begin nph = P_PUSH; m_data = rsp_data; end
                    P_WR:   if (rsp_wrc) nph = P_IDLE;
                    P_PUSH: if (rd_ready) nph = P_IDLE;
                    P_WINT: if (m_pend) nph = P_IDLE;
                    default: nph = P_IDLE;
                endcase
            end
            m_wait = (nph != m_ph) ? 0 : m_wait + 1;
            m_ph   = nph;
            rise   = m_smp[1] & ~m_smp[2];
            if (clr) m_pend = 1'b0;
            else if (rise) m_pend = 1'b1;
            else if (e_intr) m_pend = 1'b0;
            m_smp = {m_smp[1:0], dla_intr};
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [31:0] w, input logic wr,
                            input logic wi, output int sc);
        tick();
        ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.addr = a; ctrl.wdat = w;
        ctrl.write = wr; ctrl.wait_intr = wi;
        sc = cyc;
        tick();
        ctrl.start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!flags.csb_ready && k < 100) begin tick(); k++; end
        chk(name, flags.csb_ready, 1'b1);
    endtask

    initial begin
        int sc, ec, base, k, d, rc;
        ctrl = '0; req_ready = 1'b1; rsp_valid = 1'b0; rsp_wrc = 1'b0; rsp_data = '0;
        dla_intr = 1'b0; rd_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        chk("after_reset_ready", flags.csb_ready, 1'b1);

        // Read 0x5004, response two WAIT_RD cycles in
        base = n_cv;
        do_start(32'h0000_5004, 32'h0, 1'b0, 1'b0, sc);
        tick(); tick();
        rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
        tick();
        rsp_valid = 1'b0;
        wait_idle("rd_idle");
        chk("rd_addr", hs_addr, 32'h0000_1401);
        chk("rd_pulses", n_cv - base, 1);
        chk("rd_data_out", last_rdata, 32'hDEAD_BEEF);
        chk("rd_cv_cycle", cv_cyc, sc + 4);

        // Minimum latency: everything immediate, responses in IDLE/REQ discarded
        rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
        do_start(32'h0000_0100, 32'h0, 1'b0, 1'b0, sc);
        wait_idle("lat_idle");
        rsp_valid = 1'b0;
        chk("lat_cycles", cv_cyc - sc, 3);
        chk("lat_data", last_rdata, 32'h1234_5678);
        tick(); tick();

        // Write with 5 stalled request cycles
        base = n_wrc; n_stall_req = 0; req_ready = 1'b0;
        do_start(32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0, sc);
        repeat (5) tick();
        req_ready = 1'b1;
        tick();
        rsp_wrc = 1'b1;
        tick();
        rsp_wrc = 1'b0;
        wait_idle("wr_idle");
        chk("wr_stall", n_stall_req, 5);
        chk("wr_addr", hs_addr, 32'h0000_0004);
        chk("wr_wdat", hs_wdat, 32'h0000_0001);
        chk("wr_write", hs_write, 1'b1);
        chk("wr_nposted", hs_nposted, 1'b1);
        chk("wr_pulses", n_wrc - base, 1);

        // Interrupt edge 10 cycles after WAIT_INTR entry
        base = n_intr;
        do_start(32'h0, 32'h0, 1'b0, 1'b1, sc);
        repeat (9) tick();
        dla_intr = 1'b1; ec = cyc;
        k = 0;
        while (n_intr == base && k < 20) begin tick(); k++; end
        d = intr_cyc - ec;
        chk("intr_latency_2to3", (d == 2 || d == 3), 1'b1);
        chk("intr_pulses", n_intr - base, 1);
        wait_idle("intr_idle");
        dla_intr = 1'b0;
        repeat (4) tick();

        // Edge before start: pending already set on WAIT_INTR entry
        dla_intr = 1'b1;
        repeat (5) tick();
        do_start(32'h0, 32'h0, 1'b0, 1'b1, sc);
        tick();
        chk("intr_pre_cycle", intr_cyc, sc + 1);
        dla_intr = 1'b0;
        wait_idle("intr_pre_idle");

        // Read timeout, then a late response must be ignored
        base = n_err; rc = n_cv;
        do_start(32'h0000_2000, 32'h0, 1'b0, 1'b0, sc);
        k = 0;
        while (n_err == base && k < 40) begin tick(); k++; end
        chk("tmo_cycle", err_cyc, sc + 17);
        chk("tmo_ready_next", flags.csb_ready, 1'b1);
        rsp_valid = 1'b1; rsp_data = 32'h0000_0BAD;
        tick();
        rsp_valid = 1'b0;
        repeat (3) tick();
        chk("tmo_late_discard", n_cv - rc, 0);
        chk("tmo_pulses", n_err - base, 1);

        // Soft clear in WAIT_RD: back to IDLE, no flags
        base = n_cv + n_wrc + n_intr + n_err;
        do_start(32'h0000_3000, 32'h0, 1'b0, 1'b0, sc);
        tick();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr_idle", flags.csb_ready, 1'b1);
        repeat (2) tick();
        chk("clr_no_flags", n_cv + n_wrc + n_intr + n_err - base, 0);

        // ctrl.clear in REQ drops the request immediately
        req_ready = 1'b0;
        do_start(32'h0000_3008, 32'h0, 1'b0, 1'b0, sc);
        ctrl.clear = 1'b1;
        #1 chk("cclr_req_valid", req_valid, 1'b0);
        tick();
        ctrl.clear = 1'b0;
        chk("cclr_idle", flags.csb_ready, 1'b1);
        req_ready = 1'b1;

        // PUSH held by rdata_o.ready=0 for 4 cycles
        base = n_cv; n_stall_push = 0;
        rd_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
        do_start(32'h0000_3004, 32'h0, 1'b0, 1'b0, sc);
        tick();
        tick();
        rsp_valid = 1'b0;
        repeat (4) tick();
        rd_ready = 1'b1;
        tick();
        wait_idle("push_idle");
        chk("push_stall", n_stall_push, 4);
        chk("push_pulses", n_cv - base, 1);
        chk("push_data", last_rdata, 32'hCAFE_F00D);
        chk("push_cv_cycle", cv_cyc, sc + 7);

        // Reset during REQ, then an immediate request after release
        req_ready = 1'b0;
        do_start(32'h0000_4000, 32'h0, 1'b0, 1'b0, sc);
        chk("pre_rst_req_valid", req_valid, 1'b1);
        #1 rst_ni = 1'b0;
        #1 chk("rst_req_drop", req_valid, 1'b0);
        chk("rst_async_ready", flags.csb_ready, 1'b1);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        base = n_cv;
        req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'h0BAD_F00D;
        ctrl.start = 1'b1; ctrl.enable = 1'b1; ctrl.addr = 32'h0000_5008;
        ctrl.write = 1'b0; ctrl.wait_intr = 1'b0;
        rc = cyc;
        tick();
        ctrl.start = 1'b0;
        wait_idle("post_rst_idle");
        rsp_valid = 1'b0;
        chk("post_rst_addr", hs_addr, 32'h0000_1402);
        chk("post_rst_pulses", n_cv - base, 1);
        chk("post_rst_cv_cycle", cv_cyc, rc + 3);
        chk("post_rst_data", last_rdata, 32'h0BAD_F00D);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
